// File: rtl/gpio_input_conditioner.sv
// Per-bit GPIO input conditioner: pad synchroniser, debounce, rise/fall event pulses.
// Optional sticky event flags and interrupt output when GPIO_IN_IRQ_EN is defined.
module gpio_input_conditioner #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`ifdef GPIO_IN_IRQ_EN
    ,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] irq_pending,
    output logic             irq
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_disagree;
    logic [WIDTH-1:0] w_at_max;
    logic [WIDTH-1:0] w_accept;

    // Synchroniser chain; the last stage feeds the debouncers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= pins_in;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // A bit is accepted on the cycle its disagreement run reaches the full length
    always_comb begin
        w_disagree = w_sync ^ r_level;
        w_at_max   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_at_max[i] = (r_cnt[i] == CNT_MAX);
        end
        w_accept = w_disagree & w_at_max;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (!w_disagree[i] || w_at_max[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Level update and event pulses share one edge so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_level <= r_level ^ w_accept;
            r_rise  <= w_accept & w_sync;
            r_fall  <= w_accept & ~w_sync;
        end
    end

    assign gpio_in    = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

`ifdef GPIO_IN_IRQ_EN
    logic [WIDTH-1:0] r_pending;
    logic             r_irq;
    logic [WIDTH-1:0] w_pending_next;

    // Set has priority over a same-cycle clear
    always_comb begin
        w_pending_next = (r_pending & ~irq_clear) | r_rise | r_fall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_irq     <= |w_pending_next;
        end
    end

    assign irq_pending = r_pending;
    assign irq         = r_irq;
`endif

endmodule
